// File: rtl/wb_decode_pkg.sv
// Shared types and constants for the parametrised Wishbone slave selector.
package wb_decode_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    ERR    = 2'd2
  } state_t;

  localparam logic [1:0] ERR_NOMATCH = 2'b01;
  localparam logic [1:0] ERR_MULTI   = 2'b10;
  localparam logic [1:0] ERR_TIMEOUT = 2'b11;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_EOB     = 3'b111;

  // A classic cycle or end-of-burst releases the pinned slave for re-decode.
  function automatic logic burst_end(input logic [2:0] cti);
    return (cti == CTI_CLASSIC) || (cti == CTI_EOB);
  endfunction

endpackage

// File: rtl/wb_addr_match.sv
// Combinational base/mask address match across all enabled slaves.
module wb_addr_match #(
  parameter int                         SLAVES     = 4,
  parameter int                         ADDR_WIDTH = 32,
  parameter int                         IDX_WIDTH  = 2,
  parameter logic [SLAVES-1:0]          S_ENABLE   = '1,
  parameter logic [SLAVES*ADDR_WIDTH-1:0] S_BASE   = '0,
  parameter logic [SLAVES*ADDR_WIDTH-1:0] S_MASK   = '0
) (
  input  logic [ADDR_WIDTH-1:0] adr,
  output logic [SLAVES-1:0]     match,
  output logic                  multi,
  output logic [IDX_WIDTH-1:0]  idx
);

  always_comb begin
    match = '0;
    idx   = '0;
    for (int i = 0; i < SLAVES; i++) begin
      match[i] = S_ENABLE[i] &&
                 ((adr & S_MASK[i*ADDR_WIDTH +: ADDR_WIDTH]) ==
                  (S_BASE[i*ADDR_WIDTH +: ADDR_WIDTH] & S_MASK[i*ADDR_WIDTH +: ADDR_WIDTH]));
    end
    // Lowest matching index; only meaningful when exactly one bit is set.
    for (int i = SLAVES - 1; i >= 0; i--) begin
      if (match[i]) idx = IDX_WIDTH'(i);
    end
  end

  // Clearing the lowest set bit leaves something only if two or more matched.
  assign multi = (match & (match - SLAVES'(1))) != '0;

endmodule

// File: rtl/wb_decode_tmo.sv
// Wishbone B3 slave selector: registered decode, burst pinning, and bus-error
// termination with status for decode misses, overlaps and hung slaves.
module wb_decode_tmo
  import wb_decode_pkg::*;
#(
  parameter int                           SLAVES     = 4,
  parameter int                           ADDR_WIDTH = 32,
  parameter int                           DATA_WIDTH = 32,
  localparam int                          SEL_WIDTH  = DATA_WIDTH / 8,
  parameter logic [SLAVES-1:0]            S_ENABLE   = '1,
  parameter logic [SLAVES*ADDR_WIDTH-1:0] S_BASE     = '0,
  parameter logic [SLAVES*ADDR_WIDTH-1:0] S_MASK     = '0,
  parameter int                           TIMEOUT    = 255
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic [ADDR_WIDTH-1:0]        m_adr_i,
  input  logic [DATA_WIDTH-1:0]        m_dat_i,
  input  logic [SEL_WIDTH-1:0]         m_sel_i,
  input  logic                         m_we_i,
  input  logic [2:0]                   m_cti_i,
  input  logic [1:0]                   m_bte_i,
  input  logic                         m_cyc_i,
  input  logic                         m_stb_i,
  output logic [DATA_WIDTH-1:0]        m_dat_o,
  output logic                         m_ack_o,
  output logic                         m_err_o,
  output logic                         m_rty_o,
  output logic [SLAVES*ADDR_WIDTH-1:0] s_adr_o,
  output logic [SLAVES*DATA_WIDTH-1:0] s_dat_o,
  output logic [SLAVES*SEL_WIDTH-1:0]  s_sel_o,
  output logic [SLAVES-1:0]            s_we_o,
  output logic [SLAVES*3-1:0]          s_cti_o,
  output logic [SLAVES*2-1:0]          s_bte_o,
  output logic [SLAVES-1:0]            s_cyc_o,
  output logic [SLAVES-1:0]            s_stb_o,
  input  logic [SLAVES*DATA_WIDTH-1:0] s_dat_i,
  input  logic [SLAVES-1:0]            s_ack_i,
  input  logic [SLAVES-1:0]            s_err_i,
  input  logic [SLAVES-1:0]            s_rty_i,
  output logic                         err_valid_o,
  output logic [1:0]                   err_type_o,
  output logic [ADDR_WIDTH-1:0]        err_adr_o
);

  localparam int IDX_WIDTH = (SLAVES > 1) ? $clog2(SLAVES) : 1;
  localparam int TO_WIDTH  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  // Handshake: a beat terminates when m_stb_i is high together with the
  // selected slave's ack, err or rty; nothing else advances a transfer.

  state_t                  state;
  logic [IDX_WIDTH-1:0]    sel_q;
  logic [TO_WIDTH-1:0]     to_q;
  logic                    err_valid_q;
  logic [1:0]              err_type_q;
  logic [ADDR_WIDTH-1:0]   err_adr_q;

  logic [SLAVES-1:0]       match;
  logic                    multi;
  logic [IDX_WIDTH-1:0]    idx;
  logic                    sel_ack, sel_err, sel_rty, term;

  wb_addr_match #(
    .SLAVES     (SLAVES),
    .ADDR_WIDTH (ADDR_WIDTH),
    .IDX_WIDTH  (IDX_WIDTH),
    .S_ENABLE   (S_ENABLE),
    .S_BASE     (S_BASE),
    .S_MASK     (S_MASK)
  ) u_match (
    .adr   (m_adr_i),
    .match (match),
    .multi (multi),
    .idx   (idx)
  );

  assign s_adr_o = {SLAVES{m_adr_i}};
  assign s_dat_o = {SLAVES{m_dat_i}};
  assign s_sel_o = {SLAVES{m_sel_i}};
  assign s_we_o  = {SLAVES{m_we_i}};
  assign s_cti_o = {SLAVES{m_cti_i}};
  assign s_bte_o = {SLAVES{m_bte_i}};

  assign sel_ack = s_ack_i[sel_q];
  assign sel_err = s_err_i[sel_q];
  assign sel_rty = s_rty_i[sel_q];
  assign term    = m_stb_i && (sel_ack || sel_err || sel_rty);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state       <= IDLE;
      sel_q       <= '0;
      to_q        <= '0;
      err_valid_q <= 1'b0;
      err_type_q  <= 2'b00;
      err_adr_q   <= '0;
    end else begin
      err_valid_q <= 1'b0;
      case (state)
        IDLE: begin
          if (m_cyc_i && m_stb_i) begin
            if ((match != '0) && !multi) begin
              sel_q <= idx;
              to_q  <= '0;
              state <= ACCESS;
            end else begin
              state       <= ERR;
              err_valid_q <= 1'b1;
              err_type_q  <= multi ? ERR_MULTI : ERR_NOMATCH;
              err_adr_q   <= m_adr_i;
            end
          end
        end
        ACCESS: begin
          if (!m_cyc_i) begin
            // Master abort: silently release the slave.
            state <= IDLE;
            to_q  <= '0;
          end else if (term) begin
            to_q <= '0;
            if (burst_end(m_cti_i)) state <= IDLE;
          end else if (m_stb_i && (TIMEOUT != 0)) begin
            if (to_q == TO_WIDTH'(TIMEOUT - 1)) begin
              state       <= ERR;
              to_q        <= '0;
              err_valid_q <= 1'b1;
              err_type_q  <= ERR_TIMEOUT;
              err_adr_q   <= m_adr_i;
            end else begin
              to_q <= to_q + TO_WIDTH'(1);
            end
          end
        end
        ERR:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Gated strobes and the response mux depend only on state, so an async
  // reset clears them without waiting for an edge.
  always_comb begin
    s_cyc_o = '0;
    s_stb_o = '0;
    m_dat_o = '0;
    m_ack_o = 1'b0;
    m_err_o = 1'b0;
    m_rty_o = 1'b0;
    case (state)
      ACCESS: begin
        s_cyc_o[sel_q] = m_cyc_i;
        s_stb_o[sel_q] = m_stb_i;
        m_dat_o        = s_dat_i[sel_q*DATA_WIDTH +: DATA_WIDTH];
        m_ack_o        = sel_ack;
        m_err_o        = sel_err;
        m_rty_o        = sel_rty;
      end
      ERR:     m_err_o = m_cyc_i && m_stb_i;
      default: ;
    endcase
  end

  assign err_valid_o = err_valid_q;
  assign err_type_o  = err_type_q;
  assign err_adr_o   = err_adr_q;

endmodule

// File: tb/tb_wb_decode_tmo.sv
// Directed bench for wb_decode_tmo: driver tasks push expected responses,
// a negedge monitor pops and compares them as the DUT presents them.
module tb_wb_decode_tmo;

  localparam int SLAVES = 5;
  localparam int AW     = 32;
  localparam int DW     = 32;
  localparam int SW     = DW / 8;
  localparam int TMO    = 8;

  // Slave 3 is disabled; slave 4 overlaps slave 0 for the multi-match case.
  localparam logic [SLAVES-1:0]    EN   = 5'b10111;
  localparam logic [SLAVES*AW-1:0] BASE = {32'h0000_0000, 32'hC000_0000, 32'h8000_0000,
                                           32'h4000_0000, 32'h0000_0000};
  localparam logic [SLAVES*AW-1:0] MASK = {SLAVES{32'hC000_0000}};

  localparam logic [2:0] CTI_CL   = 3'b000;
  localparam logic [2:0] CTI_INC  = 3'b010;
  localparam logic [2:0] CTI_END  = 3'b111;

  logic clk, rst;
  logic [AW-1:0] m_adr;
  logic [DW-1:0] m_dat;
  logic [SW-1:0] m_sel;
  logic          m_we;
  logic [2:0]    m_cti;
  logic [1:0]    m_bte;
  logic          m_cyc, m_stb;
  logic [DW-1:0] m_dat_o;
  logic          m_ack_o, m_err_o, m_rty_o;
  logic [SLAVES*AW-1:0] s_adr_o;
  logic [SLAVES*DW-1:0] s_dat_o;
  logic [SLAVES*SW-1:0] s_sel_o;
  logic [SLAVES-1:0]    s_we_o;
  logic [SLAVES*3-1:0]  s_cti_o;
  logic [SLAVES*2-1:0]  s_bte_o;
  logic [SLAVES-1:0]    s_cyc_o, s_stb_o;
  logic [SLAVES*DW-1:0] s_dat_i;
  logic [SLAVES-1:0]    s_ack_i, s_err_i, s_rty_i;
  logic                 err_valid_o;
  logic [1:0]           err_type_o;
  logic [AW-1:0]        err_adr_o;
  logic [SLAVES-1:0]    ack_en;

  int checks = 0;
  int errors = 0;
  logic [33:0] exp_q[$];   // {ack, err, data}
  logic [33:0] err_q[$];   // {type, addr}
  logic [33:0] mon_e, mon_a;

  wb_decode_tmo #(
    .SLAVES(SLAVES), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
    .S_ENABLE(EN), .S_BASE(BASE), .S_MASK(MASK), .TIMEOUT(TMO)
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .m_adr_i(m_adr), .m_dat_i(m_dat), .m_sel_i(m_sel), .m_we_i(m_we),
    .m_cti_i(m_cti), .m_bte_i(m_bte), .m_cyc_i(m_cyc), .m_stb_i(m_stb),
    .m_dat_o(m_dat_o), .m_ack_o(m_ack_o), .m_err_o(m_err_o), .m_rty_o(m_rty_o),
    .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o), .s_we_o(s_we_o),
    .s_cti_o(s_cti_o), .s_bte_o(s_bte_o), .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o),
    .s_dat_i(s_dat_i), .s_ack_i(s_ack_i), .s_err_i(s_err_i), .s_rty_i(s_rty_i),
    .err_valid_o(err_valid_o), .err_type_o(err_type_o), .err_adr_o(err_adr_o)
  );

  // Slave models: fixed read data per slave, ack whenever strobed and enabled.
  for (genvar g = 0; g < SLAVES; g++) begin : g_slv
    assign s_dat_i[g*DW +: DW] = 32'hD0D0_0000 + 32'(g);
  end
  assign s_ack_i = s_stb_o & ack_en;
  assign s_err_i = '0;
  assign s_rty_i = '0;

  function automatic logic [DW-1:0] slave_dat(input int i);
    return 32'hD0D0_0000 + 32'(i);
  endfunction

  // Clock/reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor
  always @(negedge clk) begin
    if (!rst) begin
      if (m_cyc && m_stb && (m_ack_o || m_err_o)) begin
        mon_a = {m_ack_o, m_err_o, m_dat_o};
        if (exp_q.size() == 0) begin
          check("unexpected_resp", 64'(mon_a), 64'h0);
        end else begin
          mon_e = exp_q.pop_front();
          if (mon_e[33]) check("resp_ack_data", 64'(mon_a), 64'(mon_e));
          else           check("resp_err", 64'(mon_a[33:32]), 64'(mon_e[33:32]));
        end
      end
      if (err_valid_o) begin
        mon_a = {err_type_o, err_adr_o};
        if (err_q.size() == 0) begin
          check("unexpected_err_valid", 64'(mon_a), 64'h0);
        end else begin
          mon_e = err_q.pop_front();
          check("err_status", 64'(mon_a), 64'(mon_e));
        end
      end
    end
  end

  // Driver tasks
  task automatic drive(input logic [AW-1:0] adr, input logic [2:0] cti);
    @(posedge clk); #1;
    m_adr = adr; m_cti = cti; m_cyc = 1'b1; m_stb = 1'b1;
  endtask

  task automatic release_bus();
    @(posedge clk); #1;
    m_cyc = 1'b0; m_stb = 1'b0; m_cti = CTI_CL;
  endtask

  // Single classic request: idle during the decode cycle, exp_stb one cycle later.
  task automatic access(input string name, input logic [AW-1:0] adr, input logic [SLAVES-1:0] exp_stb);
    drive(adr, CTI_CL);
    @(negedge clk);
    check({name, "_decode_cycle_stb"}, 64'(s_stb_o), 64'h0);
    @(negedge clk);
    check({name, "_stb"}, 64'(s_stb_o), 64'(exp_stb));
    check({name, "_cyc"}, 64'(s_cyc_o), 64'(exp_stb));
    release_bus();
  endtask

  initial begin
    rst = 1'b1;
    m_adr = 32'h1234_5678; m_dat = 32'hCAFE_F00D; m_sel = 4'hF; m_we = 1'b0;
    m_cti = CTI_CL; m_bte = 2'b00; m_cyc = 1'b0; m_stb = 1'b0;
    ack_en = '1;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_s_cyc", 64'(s_cyc_o), 64'h0);
    check("rst_s_stb", 64'(s_stb_o), 64'h0);
    check("rst_m_resp", 64'({m_ack_o, m_err_o, m_rty_o}), 64'h0);
    check("rst_m_dat", 64'(m_dat_o), 64'h0);
    check("rst_err_status", 64'({err_valid_o, err_type_o, err_adr_o}), 64'h0);
    check("rst_bcast_adr", 64'(s_adr_o[4*AW +: AW]), 64'h1234_5678);
    check("rst_bcast_dat", 64'(s_dat_o[2*DW +: DW]), 64'hCAFE_F00D);
    rst = 1'b0;

    // Classic read from slave 2
    exp_q.push_back({1'b1, 1'b0, slave_dat(2)});
    access("read_s2", 32'h8000_0010, 5'b00100);

    // Disabled slave 3: no match
    exp_q.push_back({1'b0, 1'b1, 32'h0});
    err_q.push_back({2'b01, 32'hC000_0000});
    access("nomatch", 32'hC000_0000, 5'b00000);
    @(negedge clk);
    check("nomatch_hold", 64'({err_valid_o, err_type_o, err_adr_o}), 64'({1'b0, 2'b01, 32'hC000_0000}));

    // Slaves 0 and 4 overlap
    exp_q.push_back({1'b0, 1'b1, 32'h0});
    err_q.push_back({2'b10, 32'h0000_0100});
    access("multi", 32'h0000_0100, 5'b00000);

    // Hung slave 2: 8 strobed cycles, then error
    ack_en[2] = 1'b0;
    exp_q.push_back({1'b0, 1'b1, 32'h0});
    err_q.push_back({2'b11, 32'h8000_0020});
    drive(32'h8000_0020, CTI_CL);
    @(negedge clk);
    for (int k = 1; k <= TMO; k++) begin
      @(negedge clk);
      check("tmo_stb_held", 64'(s_stb_o), 64'b00100);
    end
    @(negedge clk);
    check("tmo_err_cycle_stb", 64'(s_stb_o), 64'h0);
    check("tmo_m_err", 64'(m_err_o), 64'h1);
    release_bus();

    // Ack in the last counted cycle beats the timeout
    exp_q.push_back({1'b1, 1'b0, slave_dat(2)});
    drive(32'h8000_0030, CTI_CL);
    @(negedge clk);
    for (int k = 1; k < TMO; k++) begin
      @(negedge clk);
      check("late_ack_wait", 64'({s_stb_o, m_ack_o}), 64'({5'b00100, 1'b0}));
    end
    @(posedge clk); #1;
    ack_en[2] = 1'b1;
    @(negedge clk);
    check("late_ack", 64'({m_ack_o, m_err_o}), 64'b10);
    release_bus();
    @(negedge clk);
    check("late_ack_no_err", 64'({err_valid_o, err_type_o}), 64'({1'b0, 2'b11}));

    // Incrementing burst to slave 1, then a classic read with one idle cycle
    for (int b = 0; b < 4; b++) exp_q.push_back({1'b1, 1'b0, slave_dat(1)});
    exp_q.push_back({1'b1, 1'b0, slave_dat(2)});
    drive(32'h4000_0000, CTI_INC);
    @(negedge clk);
    check("burst_decode_cycle", 64'(s_stb_o), 64'h0);
    for (int b = 0; b < 4; b++) begin
      @(posedge clk); #1;
      m_adr = 32'h4000_0000 + 32'(4 * b);
      m_cti = (b == 3) ? CTI_END : CTI_INC;
      @(negedge clk);
      check("burst_beat", 64'({s_stb_o, m_ack_o}), 64'({5'b00010, 1'b1}));
    end
    drive(32'h8000_0010, CTI_CL);
    @(negedge clk);
    check("burst_idle_gap", 64'(s_stb_o), 64'h0);
    @(negedge clk);
    check("after_burst_stb", 64'(s_stb_o), 64'b00100);
    release_bus();

    // Master abort mid-access
    ack_en[1] = 1'b0;
    drive(32'h4000_0040, CTI_CL);
    @(negedge clk);
    repeat (3) begin
      @(negedge clk);
      check("abort_wait_stb", 64'(s_stb_o), 64'b00010);
    end
    release_bus();
    @(negedge clk);
    check("abort_cyc", 64'({s_cyc_o, m_err_o}), 64'h0);
    @(negedge clk);
    check("abort_no_err", 64'(err_valid_o), 64'h0);
    ack_en[1] = 1'b1;
    exp_q.push_back({1'b1, 1'b0, slave_dat(1)});
    access("after_abort", 32'h4000_0000, 5'b00010);

    // Async reset mid-access
    ack_en[2] = 1'b0;
    drive(32'h8000_0000, CTI_CL);
    @(negedge clk);
    @(negedge clk);
    check("pre_rst_stb", 64'(s_stb_o), 64'b00100);
    #2 rst = 1'b1;
    #1;
    check("async_rst_gated", 64'({s_cyc_o, s_stb_o, m_err_o}), 64'h0);
    check("async_rst_status", 64'({err_valid_o, err_type_o, err_adr_o}), 64'h0);
    m_cyc = 1'b0; m_stb = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    ack_en[2] = 1'b1;
    exp_q.push_back({1'b1, 1'b0, slave_dat(2)});
    access("after_rst", 32'h8000_0004, 5'b00100);

    repeat (2) @(negedge clk);
    check("exp_q_drained", 64'(exp_q.size()), 64'h0);
    check("err_q_drained", 64'(err_q.size()), 64'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/wb_decode_tmo.md
# wb_decode_tmo

Parametrised Wishbone B3 slave selector for the network adapter and SoC bus fabric, generalising the fixed ten-slave decoder. It takes an arbitrary slave count with a base/mask memory map and a registered decode stage. It holds the selected slave across bursts and terminates decode misses, overlapping matches and hung slaves with a bus error plus a status report.

## Interface
- SLAVES, 4: number of slaves, 1..32
- ADDR_WIDTH, 32: address width in bits
- DATA_WIDTH, 32: data width in bits, multiple of 8; localparam SEL_WIDTH = DATA_WIDTH/8
- S_ENABLE, all ones: [SLAVES-1:0] per-slave enable mask
- S_BASE, 0: [SLAVES*ADDR_WIDTH-1:0] flattened base addresses, slave i at [i*ADDR_WIDTH +: ADDR_WIDTH]
- S_MASK, 0: flattened address masks, same layout; slave i matches when (m_adr_i & mask_i) == (base_i & mask_i)
- TIMEOUT, 255: cycles without termination before forced error; 0 disables; localparam TO_WIDTH = $clog2(TIMEOUT+1)
- clk_i  in  1  clock, all state on rising edge
- rst_i  in  1  reset; asynchronous, active-high
- m_adr_i/m_dat_i/m_sel_i/m_we_i/m_cti_i/m_bte_i/m_cyc_i/m_stb_i  in  ADDR_WIDTH/DATA_WIDTH/SEL_WIDTH/1/3/2/1/1  master request
- m_dat_o/m_ack_o/m_err_o/m_rty_o  out  DATA_WIDTH/1/1/1  master response
- s_adr_o/s_dat_o/s_sel_o/s_we_o/s_cti_o/s_bte_o  out  SLAVES× each width  broadcast copies of master signals
- s_cyc_o/s_stb_o  out  SLAVES  gated per slave
- s_dat_i/s_ack_i/s_err_i/s_rty_i  in  SLAVES×DATA_WIDTH/SLAVES/SLAVES/SLAVES  slave responses
- err_valid_o  out  1  one-cycle pulse per error termination
- err_type_o  out  2  01 no match, 10 multiple match, 11 timeout; held until next error
- err_adr_o  out  ADDR_WIDTH  m_adr_i captured at error decision; held

## Operation
- States: IDLE, ACCESS, ERR. Slave index sel_q [$clog2(SLAVES)] and timer to_q [TO_WIDTH] are registered.
- Broadcast signals are combinational copies in all states.
- IDLE:
  - All s_cyc_o, s_stb_o, m_ack_o, m_err_o and m_rty_o are 0; m_dat_o is 0.
  - On m_cyc_i & m_stb_i, with enabled matches counted: exactly one match latches its index into sel_q and moves to ACCESS.
  - Zero matches or more than one match moves to ERR and loads err_type_o and err_adr_o.
- ACCESS:
  - s_cyc_o[sel_q] = m_cyc_i and s_stb_o[sel_q] = m_stb_i; all other bits are 0.
  - m_dat_o/ack/err/rty are combinational copies of slave sel_q.
  - Termination is m_stb_i & (ack|err|rty). On termination to_q clears.
  - On termination with m_cti_i 000 or 111, next state is IDLE (re-decode).
  - On termination with any other m_cti_i, the state stays ACCESS (burst pinned to slave).
  - m_stb_i high without termination increments to_q. If to_q == TIMEOUT-1 in such a cycle and TIMEOUT != 0, next state is ERR with type 11.
  - m_cyc_i low leads to IDLE with no error (master abort); to_q clears.
- ERR:
  - s_cyc_o and s_stb_o are all 0; m_err_o = m_cyc_i & m_stb_i; next state is always IDLE.
  - err_valid_o pulses in the cycle ERR is entered. Its registered output is high during the ERR cycle.
- Slave-signalled err/rty are passed through and do not set status.

## Timing
- Reset values: state IDLE, sel_q 0, to_q 0, err_valid_o 0, err_type_o 00, err_adr_o 0. All gated/response outputs are 0; broadcasts follow the inputs.
- Decode latency: a request seen in IDLE at cycle N gives s_stb_o[i] at N+1. The earliest m_ack_o is N+1, combinational from the slave.
- Burst beats after the first have zero added latency. A classic-cycle back-to-back access costs one IDLE cycle each.
- Decode error: m_err_o high at N+1 for exactly one cycle, then IDLE at N+2.
- Timeout: ACCESS lasts exactly TIMEOUT cycles and m_err_o rises at N+1+TIMEOUT. A slave ack in the final counted cycle wins over the timeout.
- Reset asserted mid-ACCESS or mid-ERR drops every output to its reset value immediately, without waiting for a clock edge.

## Structure
- Package wb_decode_pkg holds:
  - the state enum typedef (IDLE, ACCESS, ERR);
  - err type constants ERR_NOMATCH=2'b01, ERR_MULTI=2'b10, ERR_TIMEOUT=2'b11;
  - CTI constants CTI_CLASSIC=3'b000, CTI_EOB=3'b111.
- Sub-module wb_addr_match is combinational: address plus S_ENABLE, S_BASE and S_MASK in; match vector, match count ≥2 flag and encoded index out.

## Test plan
- SLAVES=4, bases 0x0/0x4000_0000/0x8000_0000/0xC000_0000, mask 0xC000_0000; read 0x8000_0010 with slave 2 ack at first stb -> s_stb_o=0100 at N+1, m_ack_o and m_dat_o=s_dat_i[2] at N+1.
- Slave 3 disabled, access 0xC000_0000 -> m_err_o one cycle at N+1, err_type_o=01, err_adr_o=0xC000_0000, no s_cyc_o.
- Slaves 0 and 1 both mapped at 0x0 with mask 0x8000_0000 -> err_type_o=10, m_err_o at N+1.
- TIMEOUT=8, slave never acks -> s_stb_o high for 8 cycles, m_err_o at N+9, err_type_o=11; an ack in the 8th cycle instead gives m_ack_o and no error.
- Incrementing burst (cti 010 ×3, then 111) to slave 1 with ack every cycle -> 4 consecutive acks, no IDLE gap; the next classic access decodes after one IDLE cycle.
- rst_i asserted mid-ACCESS, and m_cyc_i dropped mid-ACCESS -> all s_cyc_o cleared asynchronously or next cycle respectively, no m_err_o, err_valid_o stays 0.
